pw_weight_loader: RTL and testbench

Weight-stream writer for the pointwise layer's weight load port. Accepts packed weights on a narrow AXI-Stream slave (DMA side), unpacks them, and drives `pw_wr_en/pw_wr_addr/pw_wr_data` one weight per cycle in linear address order (`addr = cout*CIN + cin`). Sits between the weight DMA and `pointwise_layer_stream`, and signals completion so the controller can release feature streaming.

---
 rtl/pw_loader_pkg.sv | 16 +
 rtl/pw_beat_unpack.sv | 55 +++++
 rtl/pw_weight_loader.sv | 165 ++++++++++++++++
 tb/tb_pw_weight_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pw_loader_pkg.sv
// Shared types and helpers for the pointwise weight loader.
package pw_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UNPACK = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Integer ceiling division, used to size the beat count of a full load.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/pw_beat_unpack.sv
// Beat buffer and lane sequencer: holds one stream beat and presents its
// weights one lane at a time, lane 0 first, skipping padding lanes of the
// final beat of a load.
module pw_beat_unpack #(
  parameter int DATA_W     = 8,
  parameter int BUS_W      = 32,
  parameter int LAST_LANES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [BUS_W-1:0]         beat_data,
  input  logic                     beat_final,
  input  logic                     advance,
  output logic signed [DATA_W-1:0] lane_data,
  output logic                     last_lane
);

  localparam int WPB = BUS_W / DATA_W;
  localparam int LW  = (WPB > 1) ? $clog2(WPB) : 1;

  logic [BUS_W-1:0] buffer;
  logic [LW-1:0]    lane;
  logic             final_q;
  logic [WPB-1:0]   lane_mask;

  // Capture a new beat (restarting at lane 0) or step to the next lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buffer  <= '0;
      lane    <= '0;
      final_q <= 1'b0;
    end else if (load) begin
      buffer  <= beat_data;
      lane    <= '0;
      final_q <= beat_final;
    end else if (advance && !last_lane) begin
      lane <= lane + LW'(1);
    end
  end

  // Only the final beat of a load can carry padding lanes beyond N.
  always_comb begin
    for (int i = 0; i < WPB; i++) begin
      lane_mask[i] = !final_q || (i < LAST_LANES);
    end
  end

  // Select the current lane and flag it as last when no valid lane follows.
  always_comb begin
    lane_data = buffer[int'(lane)*DATA_W +: DATA_W];
    last_lane = ((lane_mask >> (int'(lane) + 1)) == '0);
  end

endmodule

// File: rtl/pw_weight_loader.sv
// Pointwise weight loader: unpacks packed weights from an AXI-Stream slave
// and writes them one per cycle into the pointwise layer weight port.
// Optional feature macro: PW_LOADER_TLAST_CHECK_EN enables tlast length
// checking, err_len and early termination on a premature tlast.
module pw_weight_loader
  import pw_loader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CIN    = 32,
  parameter int COUT   = 64,
  parameter int BUS_W  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BUS_W-1:0]              s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic                          pw_wr_en,
  output logic [$clog2(COUT*CIN)-1:0]   pw_wr_addr,
  output logic signed [DATA_W-1:0]      pw_wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err_len
);

  localparam int N          = COUT * CIN;
  localparam int WPB        = BUS_W / DATA_W;
  localparam int NBEATS     = ceil_div(N, WPB);
  localparam int LAST_LANES = N - (NBEATS - 1) * WPB;
  localparam int AW         = $clog2(N);
  localparam int BW         = $clog2(NBEATS + 1);

  state_t                   state, next_state;
  logic [AW-1:0]            addr;
  logic [BW-1:0]            beat_cnt;
  logic                     stop_q;
  logic                     done_q;
  logic                     start_load;
  logic                     wr_en;
  logic                     hs;
  logic                     last_lane;
  logic                     beat_is_last;
  logic                     stop_in;
  logic signed [DATA_W-1:0] lane_data;

  assign hs           = s_axis_tready && s_axis_tvalid;
  assign beat_is_last = (beat_cnt == BW'(NBEATS - 1));

`ifdef PW_LOADER_TLAST_CHECK_EN
  logic err_q;

  assign stop_in = beat_is_last || s_axis_tlast;
  assign err_len = err_q;

  // Sticky length error: tlast must appear on exactly the last expected beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (start_load) begin
      err_q <= 1'b0;
    end else if (hs && (s_axis_tlast != beat_is_last)) begin
      err_q <= 1'b1;
    end
  end
`else
  logic tlast_unused;

  assign tlast_unused = s_axis_tlast;
  assign stop_in      = beat_is_last;
  assign err_len      = 1'b0;
`endif

  pw_beat_unpack #(
    .DATA_W    (DATA_W),
    .BUS_W     (BUS_W),
    .LAST_LANES(LAST_LANES)
  ) u_unpack (
    .clk       (clk),
    .reset     (reset),
    .load      (hs),
    .beat_data (s_axis_tdata),
    .beat_final(beat_is_last),
    .advance   (wr_en),
    .lane_data (lane_data),
    .last_lane (last_lane)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; tready opens in FETCH and on the last lane of a beat
  // when more beats are expected, so a waiting beat reloads without a bubble.
  always_comb begin
    next_state    = state;
    s_axis_tready = 1'b0;
    wr_en         = 1'b0;
    start_load    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = FETCH;
          start_load = 1'b1;
        end
      end
      FETCH: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          next_state = UNPACK;
        end
      end
      UNPACK: begin
        wr_en = 1'b1;
        if (last_lane) begin
          if (stop_q) begin
            next_state = DONE;
          end else begin
            s_axis_tready = 1'b1;
            next_state    = s_axis_tvalid ? UNPACK : FETCH;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Address and beat counters, end-of-load flag and the done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr     <= '0;
      beat_cnt <= '0;
      stop_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == UNPACK) && (next_state == DONE);
      if (start_load) begin
        addr     <= '0;
        beat_cnt <= '0;
        stop_q   <= 1'b0;
      end else begin
        if (wr_en && (addr != AW'(N - 1))) begin
          addr <= addr + AW'(1);
        end
        if (hs) begin
          beat_cnt <= beat_cnt + BW'(1);
          stop_q   <= stop_in;
        end
      end
    end
  end

  assign pw_wr_en   = wr_en;
  assign pw_wr_addr = wr_en ? addr : '0;
  assign pw_wr_data = wr_en ? lane_data : '0;
  assign busy       = (state == FETCH) || (state == UNPACK);
  assign done       = done_q;

endmodule

// File: tb/tb_pw_weight_loader.sv
// Directed bench for pw_weight_loader with N=8 weights in two 32-bit beats.
module tb_pw_weight_loader;

  localparam int DATA_W = 8;
  localparam int CIN    = 4;
  localparam int COUT   = 2;
  localparam int BUS_W  = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tready;
  logic              pw_wr_en;
  logic [2:0]        pw_wr_addr;
  logic signed [7:0] pw_wr_data;
  logic              busy;
  logic              done;
  logic              err_len;

  int   cmp_count = 0;
  int   fail_count = 0;
  int   cyc = 0;
  int   hs_count = 0;
  int   wr_addr_q[$];
  int   wr_data_q[$];
  int   wr_cyc_q[$];
  int   done_cyc_q[$];
  logic done_busy = 1'b0;

  pw_weight_loader #(
    .DATA_W(DATA_W),
    .CIN   (CIN),
    .COUT  (COUT),
    .BUS_W (BUS_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .pw_wr_en     (pw_wr_en),
    .pw_wr_addr   (pw_wr_addr),
    .pw_wr_data   (pw_wr_data),
    .busy         (busy),
    .done         (done),
    .err_len      (err_len)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter, advanced on every rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Log writes, done pulses and handshakes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (pw_wr_en) begin
      wr_addr_q.push_back(int'(pw_wr_addr));
      wr_data_q.push_back(int'(pw_wr_data));
      wr_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cyc_q.push_back(cyc);
      done_busy = busy;
    end
    if (s_axis_tvalid && s_axis_tready) hs_count++;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    cmp_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cyc_q.delete();
    hs_count = 0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Offer one beat and return just after the edge that accepted it.
  task automatic applyStimulus(input logic [31:0] data, input logic last);
    bit accepted = 1'b0;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge clk);
      accepted = s_axis_tready;
      @(posedge clk);
      #1;
    end
    if (!accepted) checkOutput("beat_accept_timeout", 0, 1);
  endtask

  // Expect writes addr 0..n-1 with data addr+1.
  task automatic checkWrites(input string tag, input int n_exp);
    checkOutput({tag, "_wr_count"}, wr_addr_q.size(), n_exp);
    for (int i = 0; i < n_exp; i++) begin
      if (i < wr_addr_q.size()) begin
        checkOutput($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], i);
        checkOutput($sformatf("%s_data%0d", tag, i), wr_data_q[i], i + 1);
      end
    end
  endtask

  // Expect one write per cycle, except a given cycle distance before index gap_idx.
  task automatic checkSpacing(input string tag, input int gap_idx, input int gap);
    for (int i = 1; i < wr_cyc_q.size(); i++) begin
      checkOutput($sformatf("%s_spacing%0d", tag, i), wr_cyc_q[i] - wr_cyc_q[i-1],
                  (i == gap_idx) ? gap : 1);
    end
  endtask

  // Expect one done pulse, the cycle after the final write, with busy low.
  task automatic checkDone(input string tag);
    checkOutput({tag, "_done_count"}, done_cyc_q.size(), 1);
    if (done_cyc_q.size() > 0 && wr_cyc_q.size() > 0) begin
      checkOutput({tag, "_done_cycle"}, done_cyc_q[0], wr_cyc_q[wr_cyc_q.size()-1] + 1);
      checkOutput({tag, "_busy_at_done"}, int'(done_busy), 0);
    end
  endtask

  initial begin
    // Reset state
    idleCycles(3);
    checkOutput("reset_outputs",
                int'({s_axis_tready, pw_wr_en, pw_wr_addr, pw_wr_data, busy, done, err_len}), 0);
    reset = 1'b1;
    idleCycles(2);
    checkOutput("idle_busy", int'(busy), 0);

    // Back-to-back load
    clearLog();
    pulseStart();
    checkOutput("t1_busy_after_start", int'(busy), 1);
    checkOutput("t1_tready_after_start", int'(s_axis_tready), 1);
    applyStimulus(32'h04030201, 1'b0);
    applyStimulus(32'h08070605, 1'b1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    idleCycles(12);
    checkWrites("t1", 8);
    checkSpacing("t1", -1, 1);
    checkDone("t1");
    checkOutput("t1_err_len", int'(err_len), 0);
    checkOutput("t1_handshakes", hs_count, 2);

    // Stalled source: three idle cycles at the reload point
    clearLog();
    pulseStart();
    applyStimulus(32'h04030201, 1'b0);
    s_axis_tvalid = 1'b0;
    idleCycles(6);
    applyStimulus(32'h08070605, 1'b1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    idleCycles(12);
    checkWrites("t2", 8);
    checkSpacing("t2", 4, 4);
    checkDone("t2");

    // Early tlast on beat 0, second beat offered afterwards
    clearLog();
    pulseStart();
    applyStimulus(32'h04030201, 1'b1);
    s_axis_tdata  = 32'h08070605;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    idleCycles(12);
    checkOutput("t3_tready_in_done", int'(s_axis_tready), 0);
    s_axis_tvalid = 1'b0;
`ifdef PW_LOADER_TLAST_CHECK_EN
    checkWrites("t3", 4);
    checkOutput("t3_err_len", int'(err_len), 1);
    checkOutput("t3_handshakes", hs_count, 1);
`else
    checkWrites("t3", 8);
    checkOutput("t3_err_len", int'(err_len), 0);
    checkOutput("t3_handshakes", hs_count, 2);
`endif
    checkDone("t3");

    // Missing tlast on the final beat, extra beat offered afterwards
    clearLog();
    pulseStart();
    applyStimulus(32'h04030201, 1'b0);
    applyStimulus(32'h08070605, 1'b0);
    s_axis_tdata = 32'h0C0B0A09;
    idleCycles(12);
    checkOutput("t4_tready_in_done", int'(s_axis_tready), 0);
    s_axis_tvalid = 1'b0;
    checkWrites("t4", 8);
    checkDone("t4");
    checkOutput("t4_handshakes", hs_count, 2);
`ifdef PW_LOADER_TLAST_CHECK_EN
    checkOutput("t4_err_len", int'(err_len), 1);
`else
    checkOutput("t4_err_len", int'(err_len), 0);
`endif

    // Reset mid-load after the addr 2 write, then a clean reload
    clearLog();
    pulseStart();
    applyStimulus(32'h04030201, 1'b0);
    s_axis_tvalid = 1'b0;
    idleCycles(2);
    @(negedge clk);
    checkOutput("t5_addr_before_reset", int'(pw_wr_addr), 2);
    checkOutput("t5_err_cleared_by_start", int'(err_len), 0);
    #1 reset = 1'b0;
    #1;
    checkOutput("t5_outputs_in_reset",
                int'({s_axis_tready, pw_wr_en, pw_wr_addr, pw_wr_data, busy, done, err_len}), 0);
    idleCycles(2);
    reset = 1'b1;
    idleCycles(2);
    clearLog();
    pulseStart();
    applyStimulus(32'h04030201, 1'b0);
    applyStimulus(32'h08070605, 1'b1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    idleCycles(12);
    checkWrites("t5", 8);
    checkDone("t5");

    // Signed lanes and a start pulse that lands during UNPACK
    clearLog();
    pulseStart();
    applyStimulus(32'h80FF7F01, 1'b0);
    s_axis_tvalid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("t6_busy_after_stray_start", int'(busy), 1);
    checkOutput("t6_addr_after_stray_start", int'(pw_wr_addr), 1);
    applyStimulus(32'h08070605, 1'b1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    idleCycles(12);
    checkOutput("t6_wr_count", wr_addr_q.size(), 8);
    if (wr_data_q.size() == 8) begin
      checkOutput("t6_data0", wr_data_q[0], 1);
      checkOutput("t6_data1", wr_data_q[1], 127);
      checkOutput("t6_data2", wr_data_q[2], -1);
      checkOutput("t6_data3", wr_data_q[3], -128);
      for (int i = 0; i < 8; i++) begin
        checkOutput($sformatf("t6_addr%0d", i), wr_addr_q[i], i);
      end
      for (int i = 4; i < 8; i++) begin
        checkOutput($sformatf("t6_data%0d", i), wr_data_q[i], i + 1);
      end
    end
    checkSpacing("t6", -1, 1);
    checkDone("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
